mmio_timer: RTL and testbench

Memory-mapped countdown timer that answers the MIPS monocycle data-memory bus: the responder side of the processor's `ce`/`wbe`/address/data interface. It sits beside the data memory and claims one 16-byte window. Reads return register contents within the same cycle, so a `lw` completes in one instruction. Writes are committed on the rising clock edge, and the block raises `irq` when the count expires.

---
 rtl/mmio_timer_pkg.sv | 33 +++
 rtl/mmio_timer_if.sv | 15 +
 rtl/mmio_timer_tick_prescaler.sv | 32 +++
 rtl/mmio_timer.sv | 102 ++++++++++
 tb/tb_mmio_timer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mmio_timer_pkg.sv
// mmio_pkg: shared constants and types for the mmio_timer block.
//   - register offsets within the 16-byte window (address[3:2])
//   - CTRL bit indices and the packed CTRL register type
//   - be_merge(): byte-enable merge of write data into a 32-bit register
package mmio_pkg;

  localparam logic [1:0] CTRL_OFS   = 2'd0;
  localparam logic [1:0] LOAD_OFS   = 2'd1;
  localparam logic [1:0] COUNT_OFS  = 2'd2;
  localparam logic [1:0] STATUS_OFS = 2'd3;

  localparam int EN_BIT   = 0;
  localparam int AUTO_BIT = 1;
  localparam int IE_BIT   = 2;

  // Field order places en at bit 0, matching EN_BIT/AUTO_BIT/IE_BIT.
  typedef struct packed {
    logic ie;
    logic auto_rl;
    logic en;
  } timer_ctrl_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// mmio_timer_if: processor data-memory bus as seen by a memory-mapped slave.
//   ce       strobe, wbe byte write enables (0 = read), address, data_in
//   data_out combinational read data, hit = access falls in slave window
// master: processor side, slave: peripheral side.
interface mmio_timer_if;
  logic        ce;
  logic [3:0]  wbe;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        hit;

  modport master (output ce, wbe, address, data_in, input  data_out, hit);
  modport slave  (input  ce, wbe, address, data_in, output data_out, hit);
endinterface

// File: rtl/mmio_timer_tick_prescaler.sv
// tick_prescaler: divides the clock into count ticks.
//   clk, rst  clock and synchronous active-high reset
//   enable    counts 0..PRESCALE-1 while high, holds while low
//   clear     forces the counter to 0 (restarts the tick phase)
//   tick      high in the cycle the counter wraps; equals enable when PRESCALE=1
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(PRESCALE + 1);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) cnt_d = '0;
    else if (enable)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer on the data-memory bus.
//   clk, rst  clock and synchronous active-high reset
//   bus       slave side of the processor bus (ce/wbe/address/data_in in,
//             data_out/hit out); reads are combinational, writes commit
//             on the rising edge
//   irq       level interrupt = EXP & IE
// Registers: 0x0 CTRL {IE,AUTO,EN}, 0x4 LOAD, 0x8 COUNT (RO), 0xC STATUS {EXP}, W1C.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFF0010,
  parameter int          PRESCALE     = 1
) (
  input  logic          clk,
  input  logic          rst,
  mmio_timer_if.slave   bus,
  output logic          irq
);
  timer_ctrl_t ctrl_q, ctrl_d, ctrl_wdata;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        exp_q, exp_d;

  logic        hit, wr, ctrl_wr, en_rise, tick;
  logic [1:0]  ofs;
  logic [31:0] rdata;
  logic [1:0]  unused_addr_lsb;

  assign unused_addr_lsb = bus.address[1:0];

  assign hit     = bus.ce && (bus.address[31:4] == BASE_ADDRESS[31:4]);
  assign ofs     = bus.address[3:2];
  assign wr      = hit && (bus.wbe != 4'b0000);
  // CTRL fields all live in byte 0, so only wbe[0] can change them.
  assign ctrl_wr = wr && (ofs == CTRL_OFS) && bus.wbe[0];
  assign ctrl_wdata = timer_ctrl_t'(bus.data_in[2:0]);
  assign en_rise = ctrl_wr && ctrl_wdata.en && !ctrl_q.en;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .enable (ctrl_q.en),
    .clear  (en_rise),
    .tick   (tick)
  );

  always_comb begin
    ctrl_d  = ctrl_wr ? ctrl_wdata : ctrl_q;
    load_d  = (wr && ofs == LOAD_OFS) ? be_merge(load_q, bus.data_in, bus.wbe) : load_q;
    count_d = count_q;
    exp_d   = exp_q;

    if (wr && ofs == STATUS_OFS && bus.wbe[0] && bus.data_in[0]) exp_d = 1'b0;

    // en_rise and tick are exclusive: tick needs EN already set.
    // Reload uses load_q so a same-cycle LOAD write is not seen.
    if (en_rise) begin
      count_d = load_q;
    end else if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        exp_d = 1'b1;                          // set beats a same-cycle clear
        if (ctrl_q.auto_rl) begin
          // A software EN=0 in the expiry cycle suppresses the reload.
          if (!(ctrl_wr && !ctrl_wdata.en)) count_d = load_q;
        end else if (!ctrl_wr) begin
          ctrl_d.en = 1'b0;                    // one-shot stops; software write wins
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (ofs)
      CTRL_OFS:   rdata = {29'd0, ctrl_q};
      LOAD_OFS:   rdata = load_q;
      COUNT_OFS:  rdata = count_q;
      STATUS_OFS: rdata = {31'd0, exp_q};
      default:    rdata = '0;
    endcase
  end

  assign bus.hit      = hit;
  assign bus.data_out = (hit && bus.wbe == 4'b0000) ? rdata : 32'd0;
  assign irq          = exp_q & ctrl_q.ie;
endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: two instances (PRESCALE=1 and 4) on one clock
// and reset. Expected read data is queued when a read is driven and popped
// when the combinational response is sampled.
module tb_mmio_timer;
  localparam logic [31:0] BASE = 32'hFFFF0010;
  localparam logic [31:0] CTRL = BASE + 32'h0;
  localparam logic [31:0] LOAD = BASE + 32'h4;
  localparam logic [31:0] CNT  = BASE + 32'h8;
  localparam logic [31:0] STAT = BASE + 32'hC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq_a, irq_b;

  int n_assert = 0;
  int n_fail   = 0;

  string       tag_q[$];
  logic [31:0] val_q[$];

  mmio_timer_if bus_a();
  mmio_timer_if bus_b();

  mmio_timer #(.BASE_ADDRESS(BASE), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .irq(irq_a));
  mmio_timer #(.BASE_ADDRESS(BASE), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .irq(irq_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic ce, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel) begin
      bus_b.ce = ce; bus_b.wbe = be; bus_b.address = addr; bus_b.data_in = data;
    end else begin
      bus_a.ce = ce; bus_a.wbe = be; bus_a.address = addr; bus_a.data_in = data;
    end
  endtask

  // Write commits on the next rising edge; returns 1ns after that edge.
  task automatic wr(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] be = 4'hF);
    drive(sel, 1'b1, be, addr, data);
    step();
    drive(sel, 1'b0, 4'h0, 32'd0, 32'd0);
  endtask

  // Combinational read: no clock edge consumed.
  task automatic rd(input bit sel, input logic [31:0] addr, input logic [31:0] expv,
                    input string tag);
    logic [31:0] obs;
    tag_q.push_back(tag);
    val_q.push_back(expv);
    drive(sel, 1'b1, 4'h0, addr, 32'd0);
    #2;
    obs = sel ? bus_b.data_out : bus_a.data_out;
    chk(tag_q.pop_front(), obs, val_q.pop_front());
    drive(sel, 1'b0, 4'h0, 32'd0, 32'd0);
  endtask

  initial begin
    logic saw_exp;
    drive(0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'h0, 32'd0, 32'd0);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step();

    // Reset state and window readback
    chk("irq_a_reset", {31'd0, irq_a}, 32'd0);
    chk("irq_b_reset", {31'd0, irq_b}, 32'd0);
    rd(0, CTRL, 32'd0, "ctrl_reset");
    rd(0, LOAD, 32'd0, "load_reset");
    rd(0, CNT,  32'd0, "count_reset");
    rd(0, STAT, 32'd0, "status_reset");
    drive(0, 1'b1, 4'h0, BASE + 32'h10, 32'd0);
    #2;
    chk("hit_outside", {31'd0, bus_a.hit}, 32'd0);
    chk("data_outside", bus_a.data_out, 32'd0);
    drive(0, 1'b1, 4'h0, CNT, 32'd0);
    #2;
    chk("hit_inside", {31'd0, bus_a.hit}, 32'd1);
    drive(0, 1'b0, 4'h0, 32'd0, 32'd0);

    // Byte-enable write
    wr(0, LOAD, 32'hAABBCCDD, 4'b0101);
    rd(0, LOAD, 32'h00BB00DD, "load_byte_en");
    wr(0, CNT, 32'h12345678);
    rd(0, CNT, 32'd0, "count_ro");

    // One-shot, PRESCALE=1, LOAD=3, CTRL=EN|IE at edge k
    wr(0, LOAD, 32'd3);
    wr(0, CTRL, 32'h5);
    rd(0, CNT, 32'd3, "os_count_k");
    step(); rd(0, CNT, 32'd2, "os_count_k1");
    step(); rd(0, CNT, 32'd1, "os_count_k2");
    step(); rd(0, CNT, 32'd0, "os_count_k3");
    rd(0, STAT, 32'd0, "os_exp_k3");
    chk("os_irq_k3", {31'd0, irq_a}, 32'd0);
    step();
    rd(0, STAT, 32'd1, "os_exp_k4");
    chk("os_irq_k4", {31'd0, irq_a}, 32'd1);
    rd(0, CTRL, 32'h4, "os_en_cleared");
    rd(0, CNT, 32'd0, "os_count_hold");
    step(2);
    rd(0, CNT, 32'd0, "os_no_underflow");
    wr(0, STAT, 32'd1, 4'b0001);
    rd(0, STAT, 32'd0, "os_exp_clear");
    chk("os_irq_clear", {31'd0, irq_a}, 32'd0);

    // Auto-reload, PRESCALE=4, LOAD=1, CTRL=EN|AUTO at edge k
    wr(1, LOAD, 32'd1);
    wr(1, CTRL, 32'h3);
    step(4);
    rd(1, CNT, 32'd0, "ar_count_k4");
    step(3);
    rd(1, STAT, 32'd0, "ar_exp_k7");
    step();
    rd(1, STAT, 32'd1, "ar_exp_k8");
    rd(1, CNT, 32'd1, "ar_reload");
    rd(1, CTRL, 32'h3, "ar_still_run");
    chk("ar_irq_masked", {31'd0, irq_b}, 32'd0);
    wr(1, STAT, 32'd1, 4'b0001);                 // edge k+9
    rd(1, STAT, 32'd0, "ar_clear");
    step(6);
    rd(1, STAT, 32'd0, "ar_exp_k15");
    step();
    rd(1, STAT, 32'd1, "ar_exp_k16");

    // Set-versus-clear collision at expiry edge k+24
    wr(1, STAT, 32'd1, 4'b0001);                 // edge k+17
    rd(1, STAT, 32'd0, "col_pre_clear");
    step(6);
    wr(1, STAT, 32'd1, 4'b0001);                 // edge k+24
    rd(1, STAT, 32'd1, "col_set_wins");

    // EN=0 write at expiry edge k+32: EN cleared, EXP set, no reload
    wr(1, STAT, 32'd1, 4'b0001);                 // edge k+25
    step(6);
    wr(1, CTRL, 32'h0);                          // edge k+32
    rd(1, CTRL, 32'h0, "off_ctrl");
    rd(1, STAT, 32'd1, "off_exp");
    rd(1, CNT, 32'd0, "off_no_reload");

    // Reset mid-run, PRESCALE=1, LOAD=100
    wr(0, LOAD, 32'd100);
    wr(0, CTRL, 32'h7);
    step(50);
    rd(0, CNT, 32'd50, "rst_count50");
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd(0, CTRL, 32'd0, "rst_ctrl");
    rd(0, LOAD, 32'd0, "rst_load");
    rd(0, CNT,  32'd0, "rst_count");
    rd(0, STAT, 32'd0, "rst_status");
    chk("rst_irq", {31'd0, irq_a}, 32'd0);
    rd(1, STAT, 32'd0, "rst_b_status");
    saw_exp = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      drive(0, 1'b1, 4'h0, STAT, 32'd0);
      #2;
      if (bus_a.data_out != 32'd0 || irq_a) saw_exp = 1'b1;
      drive(0, 1'b0, 4'h0, 32'd0, 32'd0);
    end
    chk("rst_no_exp_200", {31'd0, saw_exp}, 32'd0);
    rd(0, CNT, 32'd0, "rst_count_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
